// File: rtl/param_divider_if.sv
// Start/Done handshake bundle for the iterative divider.
interface param_divider_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Done;
  logic             Busy;
  logic             DivByZero;
  logic             Overflow;

  // Requester side: drives operands, observes results.
  modport master (
    output Start, Signed, Dividend, Divisor,
    input  Quotient, Remainder, Done, Busy, DivByZero, Overflow
  );

  // Divider side.
  modport slave (
    input  Start, Signed, Dividend, Divisor,
    output Quotient, Remainder, Done, Busy, DivByZero, Overflow
  );
endinterface

// File: rtl/param_divider.sv
// Iterative restoring divider, one quotient bit per clock, with signed mode
// and single-cycle exits for divide-by-zero and signed MIN/-1.
module param_divider #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           Clock,
  input  logic           Reset,
  param_divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0] shq_q, shq_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  // Operand decode: signs, magnitudes and the two exception cases.
  logic             a_neg, b_neg, is_zero, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg   = bus.Signed & bus.Dividend[WIDTH-1];
    b_neg   = bus.Signed & bus.Divisor[WIDTH-1];
    // -MIN wraps to MIN, which is the correct magnitude read as unsigned.
    a_mag   = a_neg ? (~bus.Dividend + 1'b1) : bus.Dividend;
    b_mag   = b_neg ? (~bus.Divisor  + 1'b1) : bus.Divisor;
    is_zero = (bus.Divisor == '0);
    is_ovf  = bus.Signed && (bus.Dividend == MIN_VAL) && (bus.Divisor == ONES);
  end

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  logic [WIDTH+1:0] shifted, trial;
  logic             fits;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  always_comb begin
    shifted  = {prem_q, shq_q[WIDTH-1]};
    trial    = shifted - {2'b00, dvs_q};
    fits     = ~trial[WIDTH+1];
    step_rem = fits ? trial[WIDTH:0] : shifted[WIDTH:0];
    step_quo = {shq_q[WIDTH-2:0], fits};
  end

  // Next-state and datapath update for the IDLE/WORK/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    shq_d   = shq_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = done_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          done_d = 1'b0;
          if (is_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            quo_d   = ONES;
            rem_d   = bus.Dividend;
          end else if (is_ovf) begin
            state_d = DONE;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
            quo_d   = MIN_VAL;
            rem_d   = '0;
          end else begin
            state_d = WORK;
            busy_d  = 1'b1;
            cnt_d   = '0;
            prem_d  = '0;
            shq_d   = a_mag;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
          end
        end
      end
      WORK: begin
        prem_d = step_rem;
        shq_d  = step_quo;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          quo_d   = negq_q ? (~step_quo + 1'b1) : step_quo;
          rem_d   = negr_q ? (~step_rem[WIDTH-1:0] + 1'b1) : step_rem[WIDTH-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.Start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; synchronous reset wins over everything, including WORK.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      shq_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      shq_q   <= shq_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_q;
  assign bus.Done      = done_q;
  assign bus.Busy      = busy_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Overflow  = ovf_q;

endmodule

// File: doc/param_divider.md
Name: param_divider

Overview:
Parametrised iterative restoring divider. It replaces the fixed 16-bit unsigned divider and adds a per-operation signed mode, divide-by-zero and signed-overflow detection, a busy indication, and single-cycle fast paths for exception cases. It sits in the arithmetic datapath beside the multiplier units and uses the same Start/Done level handshake.

Parameters:
WIDTH, 16, operand/result width in bits (legal 4..32)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Start  input  1  level request; sampled only in IDLE
Signed  input  1  1 = two's-complement operation; sampled with Start
Dividend  input  WIDTH  numerator; sampled with Start
Divisor  input  WIDTH  denominator; sampled with Start
Quotient  output  WIDTH  result quotient; valid while Done=1
Remainder  output  WIDTH  result remainder; valid while Done=1
Done  output  1  result valid
Busy  output  1  iteration in progress
DivByZero  output  1  last operation had Divisor=0; valid while Done=1
Overflow  output  1  last operation was signed MIN/-1; valid while Done=1

Behaviour:
- One clock. Reset is synchronous and active-high. Reset forces IDLE and sets Quotient, Remainder, Done, Busy, DivByZero, Overflow and all internal registers to 0. Reset takes priority over all other events, including mid-operation; an aborted operation produces no Done pulse.
- FSM states:
  - IDLE: Start=1 captures the operands at the edge.
    - Divisor=0: go to DONE directly.
    - Signed=1, Dividend=100..0 and Divisor=all-ones: go to DONE directly.
    - Otherwise: go to WORK with count=0, partial remainder (WIDTH+1 bits)=0, Busy=1.
  - WORK: one restoring step per edge. Shift the next operand MSB into the partial remainder and subtract the divisor magnitude. A non-negative result keeps the difference and shifts 1 into the quotient; a negative result restores and shifts 0. The edge with count=WIDTH-1 performs the last step, applies sign fix-up, loads the outputs, sets Done=1, clears Busy and enters DONE.
  - DONE: Done=1 and outputs are held. Start=0 returns to IDLE and clears Done on that edge. Start held high stays in DONE; there is no auto-restart.
  - Illegal state encoding: next state is IDLE.
- Latency:
  - Normal operation: Done visible exactly WIDTH cycles after the Start-sampling edge.
  - Fast paths: Done visible after 1 cycle.
- Signed mode:
  - Iterate on magnitudes.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend, so Dividend = Quotient*Divisor + Remainder and |Remainder| < |Divisor|.
- Unsigned mode: plain WIDTH-bit division. Dividend=all-ones is legal and is not an overflow.
- Divide by zero: Quotient=all-ones, Remainder=Dividend as captured, DivByZero=1, Overflow=0. Applies in both modes.
- Overflow (signed MIN / -1): Quotient=MIN, Remainder=0, Overflow=1, DivByZero=0.
- Flags are cleared on every accepted Start and are meaningful only while Done=1.
- Input changes while Busy or Done have no effect. Start asserted during WORK is ignored.
- Busy=1 only in WORK. Busy and Done are never high together.

Test Plan:
- WIDTH=16, unsigned 100/7 -> Done exactly 16 cycles after the Start edge, Quotient=0x000E, Remainder=0x0002, flags 0. Drop Start -> Done=0 next cycle.
- Signed 0xFF9C(-100)/0x0007 -> Quotient=0xFFF2(-14), Remainder=0xFFFE(-2). Signed 0x0064/0xFFF9 -> Quotient=0xFFF2, Remainder=0x0002.
- Unsigned 0xFFFF/0x0001 -> Quotient=0xFFFF, Remainder=0, Overflow=0. Signed 0x8000/0xFFFF -> Done after 1 cycle, Quotient=0x8000, Remainder=0, Overflow=1.
- 0x04D2/0 (both modes) -> Done after 1 cycle, Quotient=0xFFFF, Remainder=0x04D2, DivByZero=1.
- Assert Reset on the 5th WORK cycle -> next edge: IDLE, Busy=0, Done=0, outputs 0. A following 9/3 gives Quotient=3, Remainder=0.
- Hold Start high through DONE for 10 cycles while changing operands -> results unchanged, no restart. Repeat 200/13 with WIDTH=8 -> Quotient=15, Remainder=5 after 8 cycles.
